// File: rtl/bus_arbiter_fifo.sv
// Shared-bus arbiter (fixed priority or round-robin) feeding a tagged capture FIFO.
// Latency: 1 cycle from req to out_valid. Backpressure: no grants while the FIFO is full.
module bus_arbiter_fifo #(
  parameter int  DATA_WIDTH  = 64,
  parameter int  NUM_MASTERS = 4,
  parameter int  DEPTH       = 4,
  parameter int  ARB_MODE    = 0,
  localparam int SRC_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] data_in,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [SRC_W-1:0]                  out_src,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              contention,
  output logic [CNT_W-1:0]                  count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = SRC_W + DATA_WIDTH;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d, gnt_idx;
  logic                  contention_q, contention_d;
  logic [ENT_W-1:0]      mem_q [DEPTH];
  logic                  accept_en, push, pop;
  logic [DATA_WIDTH-1:0] bus_data;

  // No pop-through credit: a full FIFO blocks grants even if the head is popped this cycle.
  assign accept_en = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = |grant;
  assign pop       = out_valid && out_ready;

  always_comb begin : arb
    logic             found;
    logic [SRC_W-1:0] sel;
    int               idx;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    idx     = 0;
    if (rst_n && accept_en) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        idx = (ARB_MODE == 1) ? ((int'(rr_ptr_q) + i) % NUM_MASTERS) : i;
        sel = SRC_W'(idx);
        if (!found && req[sel]) begin
          found      = 1'b1;
          grant[sel] = 1'b1;
          gnt_idx    = sel;
        end
      end
    end
  end

  // One-hot AND-OR bus: only the granted source can contribute.
  always_comb begin
    bus_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus_data = bus_data | (data_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rr_ptr_d     = rr_ptr_q;
    contention_d = ($countones(req) >= 2) && push;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_ptr_d = (gnt_idx == SRC_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_ptr_q     <= '0;
      contention_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rr_ptr_q     <= rr_ptr_d;
      contention_q <= contention_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {gnt_idx, bus_data};
    end
  end

  // Head is gated so an empty or freshly reset FIFO presents zeros.
  assign {out_src, out_data} = out_valid ? mem_q[rd_ptr_q] : '0;
  assign contention          = contention_q;
  assign count               = count_q;
endmodule
